exe_div_ctrl: RTL

//  Multi-cycle sequencer and datapath for RV32M DIV/DIVU/REM/REMU, instantiated beside exe.
//  Exe asserts start_i while a divide sits in its stage. This block latches the operands and

---
 rtl/exe_div_ctrl_pkg.sv | 11 +
 rtl/exe_div_ctrl_if.sv | 19 +
 rtl/exe_div_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/exe_div_ctrl_pkg.sv
// exe_div_ctrl_pkg: shared widths, op/state encodings and sign helper for the divider
package exe_div_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [6:0] INST_DIV_F7 = 7'b0000001;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_CALC = 2'b01, ST_DONE = 2'b10} div_st_e;
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/exe_div_ctrl_if.sv
// exe_div_ctrl_if: exe <-> divider request/result bundle
interface exe_div_ctrl_if;
  import exe_div_ctrl_pkg::*;
  logic start;
  div_op_e op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0] rd;
  logic flush;
  logic stallreq;
  logic busy;
  logic ready;
  logic [XLEN-1:0] result;
  logic [4:0] reg_waddr;
  modport master (output start, op, dividend, divisor, rd, flush,
                  input stallreq, busy, ready, result, reg_waddr);
  modport slave (input start, op, dividend, divisor, rd, flush,
                 output stallreq, busy, ready, result, reg_waddr);
endinterface

// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module exe_div_ctrl
  import exe_div_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  exe_div_ctrl_if.slave div
);
  div_st_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  div_op_e op_q;
  logic [4:0] rd_q;
  logic [XLEN-1:0] rem, quo, dvs;
  logic qneg, rneg;
  logic go, sgn, sa, sb, dz, ov;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0] rsh, diff;
  always_comb begin
    go = (state == ST_IDLE) & div.start & ~div.flush;
    sgn = ~div.op[0];
    sa = sgn & div.dividend[XLEN-1];
    sb = sgn & div.divisor[XLEN-1];
    ma = neg_if(sa, div.dividend);
    mb = neg_if(sb, div.divisor);
    dz = div.divisor == '0;
    ov = sgn & (div.dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&div.divisor);
    rsh = {rem, quo[XLEN-1]};
    diff = rsh - {1'b0, dvs};
    state_nxt = div.flush ? ST_IDLE :
                state == ST_IDLE ? (go ? ((dz | ov) ? ST_DONE : ST_CALC) : ST_IDLE) :
                state == ST_CALC ? ((cnt == CNT_W'(XLEN-1)) ? ST_DONE : ST_CALC) : ST_IDLE;
  end
  // special cases preload the final magnitudes so DONE only needs the sign fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_q <= OP_DIV;
      rd_q <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) begin
        op_q <= div.op;
        rd_q <= div.rd;
        dvs <= mb;
        cnt <= '0;
        rem <= dz ? ma : '0;
        quo <= dz ? '1 : ov ? {1'b1, {(XLEN-1){1'b0}}} : ma;
        qneg <= ~dz & ~ov & (sa ^ sb);
        rneg <= ~ov & sa;
      end else if (state == ST_CALC) begin
        cnt <= cnt + 1'b1;
        rem <= diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ~diff[XLEN]};
      end
    end
  end
  assign div.stallreq = go | (state == ST_CALC);
  assign div.busy = state != ST_IDLE;
  assign div.ready = (state == ST_DONE) & ~div.flush;
  assign div.result = div.ready ? (op_q[1] ? neg_if(rneg, rem) : neg_if(qneg, quo)) : '0;
  assign div.reg_waddr = div.ready ? rd_q : '0;
endmodule
